alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
- Execute-stage ALU that consumes the 5-bit ALU control code produced by the decode-side ALU control logic and returns a result with a valid/ready handshake.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts are iterative, one bit position per cycle, to save area on the MPW core.
- Sits between decode/issue and writeback/branch resolution. Also provides a zero flag for BEQ/BNE.

Parameters:
- XLEN, 32, operand and result width.
- SHAMT_W, $clog2(XLEN), shift-amount width taken from op_b_i[SHAMT_W-1:0].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- alu_ctrl_i  in  5  operation code.
- op_a_i  in  XLEN  operand A.
- op_b_i  in  XLEN  operand B.
- flush_i  in  1  synchronous abort of any in-flight or held operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  registered result.
- zero_o  out  1  registered (result == 0).

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=1.
  - Internal shift count=0.
  - Reset mid-shift abandons the operation immediately.
- Operation codes:
  - ADD 5'b00000, AND 5'b00001, OR 5'b00010, XOR 5'b00011.
  - SLL 5'b00100, SRL 5'b00101, SRA 5'b00110.
  - SUB 5'b10000, SLTU 5'b11000, SLT 5'b10111.
  - Any other code executes as ADD.
- Arithmetic and width rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare; SLTU is unsigned. Both produce {XLEN-1 zeros, lt}.
  - Shift amount is op_b_i[SHAMT_W-1:0]; upper bits are ignored.
  - SRA replicates op_a_i[XLEN-1].
- State machine:
  - IDLE: ready_o=1.
    - On valid_i & ready_o & !flush_i, capture alu_ctrl_i and operands.
    - Non-shift op: compute, register result_o/zero_o, go DONE.
    - Shift with amount 0: result_o=op_a_i, go DONE.
    - Shift with amount k>0: load working register with op_a_i, count=k, go SHIFT.
  - SHIFT: ready_o=0.
    - Each cycle, shift the working register by one position in the captured direction and decrement count.
    - When count reaches 1, this cycle's shifted value plus its zero flag are registered and the state goes DONE.
  - DONE: valid_o=1, ready_o=0. result_o/zero_o stay stable until the handshake.
    - On ready_i, go IDLE.
    - ready_o rises the following cycle; there is no same-cycle accept-through.
- Latency, counting the accept edge as cycle N:
  - Non-shift op, or shift by 0: valid_o at N+1.
  - Shift by k≥1: valid_o at N+1+k.
  - Minimum issue interval is 2 cycles.
- flush_i:
  - In any state, flush_i forces the next state to IDLE and valid_o=0.
  - result_o keeps its last value.
  - A request presented in the same cycle as flush_i is not accepted.
- Stability: valid_o never drops without a ready_i handshake, except on flush_i or rst_i.
- valid_i is ignored while ready_o=0; requests are not queued.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+0x00000001 -> valid_o one cycle after accept, result_o=0x80000000, zero_o=0.
- SUB 0x00000005-0x00000005 -> result_o=0x00000000, zero_o=1. Then SLT 0xFFFFFFFF vs 0x00000001 -> result_o=1. SLTU on the same operands -> result_o=0.
- SRA 0x80000000 by op_b_i=0x00000024 (amount 4) -> valid_o exactly 5 cycles after accept, result_o=0xF8000000, ready_o low throughout.
- SLL by 0 on 0x12345678 -> result_o=0x12345678 at N+1. Undefined code 5'b01111 with 3+4 -> result_o=7.
- Hold ready_i=0 for 3 cycles in DONE -> valid_o and result_o stable. Then ready_i=1 -> valid_o=0 and ready_o=1 on the next cycle.
- Two aborts:
  - flush_i asserted on the 2nd cycle of a 10-bit SRL -> IDLE next cycle, no valid_o pulse.
  - rst_i asserted asynchronously mid-shift -> outputs go to reset values immediately.

Source files
------------

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//
// Execute-stage ALU. Takes the 5-bit ALU control code from decode-side ALU
// control and returns a registered result plus a zero flag for BEQ/BNE.
// Logic, arithmetic and compare operations complete in one cycle. Shifts
// iterate one bit position per cycle through a single working register, so
// no barrel shifter is needed.
//
// Ports:
//   clk_i       in   1     clock, rising edge
//   rst_i       in   1     asynchronous reset, active-high
//   valid_i     in   1     request valid
//   ready_o     out  1     block can accept a request (high only in IDLE)
//   alu_ctrl_i  in   5     operation code
//   op_a_i      in   XLEN  operand A
//   op_b_i      in   XLEN  operand B (shift amount is op_b_i[SHAMT_W-1:0])
//   flush_i     in   1     synchronous abort of any in-flight or held op
//   valid_o     out  1     result valid (high only in DONE)
//   ready_i     in   1     consumer accepts result
//   result_o    out  XLEN  registered result
//   zero_o      out  1     registered (result == 0)
//   state_o     out  2     current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. On the input side valid_i is only looked at while ready_o=1 and
// requests are never queued; a request presented together with flush_i is
// dropped. On the output side valid_o, result_o and zero_o hold steady until
// ready_i is seen (or flush_i/rst_i abort), and ready_o only rises on the
// cycle after the result handshake, so there is no accept-through.
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      alu_ctrl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic [1:0]      state_o
);

    // Operation codes
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b00110;
    localparam logic [4:0] OP_SUB  = 5'b10000;
    localparam logic [4:0] OP_SLTU = 5'b11000;
    localparam logic [4:0] OP_SLT  = 5'b10111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_SLL = 2'd0,
        DIR_SRL = 2'd1,
        DIR_SRA = 2'd2
    } dir_t;

    state_t             state_q;
    state_t             state_d;
    dir_t               dir_q;
    logic [XLEN-1:0]    shreg_q;
    logic [SHAMT_W-1:0] count_q;

    logic               accept;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    shift_next;
    logic               last_step;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign accept    = (state_q == S_IDLE) && valid_i && !flush_i;
    assign is_shift  = (alu_ctrl_i == OP_SLL) || (alu_ctrl_i == OP_SRL) ||
                       (alu_ctrl_i == OP_SRA);
    assign shamt     = op_b_i[SHAMT_W-1:0];
    assign last_step = (count_q == SHAMT_W'(1));

    // Single-cycle operations. Shift codes never use this value; unknown codes
    // fall into the default arm and execute as ADD.
    always_comb begin
        alu_result = op_a_i + op_b_i;
        case (alu_ctrl_i)
            OP_ADD:  alu_result = op_a_i + op_b_i;
            OP_AND:  alu_result = op_a_i & op_b_i;
            OP_OR:   alu_result = op_a_i | op_b_i;
            OP_XOR:  alu_result = op_a_i ^ op_b_i;
            OP_SUB:  alu_result = op_a_i - op_b_i;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}},
                                   ($signed(op_a_i) < $signed(op_b_i))};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
            default: alu_result = op_a_i + op_b_i;
        endcase
    end

    // One-position shift of the working register in the captured direction.
    always_comb begin
        shift_next = {shreg_q[XLEN-2:0], 1'b0};
        case (dir_q)
            DIR_SRL: shift_next = {1'b0, shreg_q[XLEN-1:1]};
            DIR_SRA: shift_next = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: shift_next = {shreg_q[XLEN-2:0], 1'b0};
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (accept) begin
                    // A zero-distance shift completes like a one-cycle op.
                    if (is_shift && (shamt != '0)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Flush wins over everything else, including a pending accept.
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    assign state_o = state_q;

    // -------------------------------------------------------------------------
    // Datapath: result, zero flag, shift working register and count
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            shreg_q  <= '0;
            count_q  <= '0;
            dir_q    <= DIR_SLL;
        end else if (flush_i) begin
            // Abandon any shift in progress; the last result stays visible.
            count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_shift) begin
                            if (shamt == '0) begin
                                result_o <= op_a_i;
                                zero_o   <= (op_a_i == '0);
                            end else begin
                                shreg_q <= op_a_i;
                                count_q <= shamt;
                                case (alu_ctrl_i)
                                    OP_SRL:  dir_q <= DIR_SRL;
                                    OP_SRA:  dir_q <= DIR_SRA;
                                    default: dir_q <= DIR_SLL;
                                endcase
                            end
                        end else begin
                            result_o <= alu_result;
                            zero_o   <= (alu_result == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    shreg_q <= shift_next;
                    count_q <= count_q - SHAMT_W'(1);
                    // The final step's value goes straight to the result so
                    // DONE follows exactly k shift cycles.
                    if (last_step) begin
                        result_o <= shift_next;
                        zero_o   <= (shift_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
